// File: rtl/exers.sv
// exers: integer execute reservation station.
//
// Holds dispatched non-memory, non-CSR micro-ops until both operands are
// ready, captures missing operands from the writeback bus by tag match, and
// issues one ready micro-op per cycle into a registered issue slot that
// honours ALU backpressure.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   rename_exers_write       dispatch write request
//   rename_op/robid/rd/imm   micro-op fields from rename/dispatch
//   rename_op1ready/op1      operand 1 value (ready) or producer tag (not ready)
//   rename_op2ready/op2      operand 2 value (ready) or producer tag (not ready)
//   exers_stall              all entries occupied; dispatch is not accepted
//   wb_valid/robid/result    writeback (result) bus
//   alu_stall                ALU cannot accept an issue this cycle
//   exers_issue_*            registered issue slot toward the ALU
//   rob_flush                pipeline flush, same effect as rst
module exers #(
    parameter int DEPTH = 8,
    parameter int TAGW  = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rename_exers_write,
    input  logic [4:0]      rename_op,
    input  logic [TAGW-1:0] rename_robid,
    input  logic [5:0]      rename_rd,
    input  logic            rename_op1ready,
    input  logic [31:0]     rename_op1,
    input  logic            rename_op2ready,
    input  logic [31:0]     rename_op2,
    input  logic [31:0]     rename_imm,
    output logic            exers_stall,
    input  logic            wb_valid,
    input  logic [TAGW-1:0] wb_robid,
    input  logic [31:0]     wb_result,
    input  logic            alu_stall,
    output logic            exers_issue_valid,
    output logic [4:0]      exers_issue_op,
    output logic [TAGW-1:0] exers_issue_robid,
    output logic [5:0]      exers_issue_rd,
    output logic [31:0]     exers_issue_op1,
    output logic [31:0]     exers_issue_op2,
    output logic [31:0]     exers_issue_imm,
    input  logic            rob_flush
);

    localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0] ent_valid;
    logic [DEPTH-1:0] ent_rdy1;
    logic [DEPTH-1:0] ent_rdy2;
    logic [4:0]       ent_op    [DEPTH];
    logic [TAGW-1:0]  ent_robid [DEPTH];
    logic [5:0]       ent_rd    [DEPTH];
    logic [31:0]      ent_val1  [DEPTH];
    logic [31:0]      ent_val2  [DEPTH];
    logic [31:0]      ent_imm   [DEPTH];

    logic             clear;
    logic             write_en;
    logic [DEPTH-1:0] eligible;
    logic             any_elig;
    logic             issue_load;
    logic [IDXW-1:0]  free_idx;
    logic [IDXW-1:0]  sel_idx;

    logic             wr_match1;
    logic             wr_match2;
    logic             wr_rdy1;
    logic             wr_rdy2;
    logic [31:0]      wr_val1;
    logic [31:0]      wr_val2;

    assign clear       = rst | rob_flush;
    assign exers_stall = &ent_valid;
    assign write_en    = rename_exers_write & ~exers_stall;
    assign eligible    = ent_valid & ent_rdy1 & ent_rdy2;
    assign any_elig    = |eligible;
    assign issue_load  = (~exers_issue_valid | ~alu_stall) & any_elig;

    // A not-ready operand whose tag is on the bus this very cycle would
    // otherwise miss its only wakeup, so it is captured on the way in.
    assign wr_match1 = wb_valid & (rename_op1[TAGW-1:0] == wb_robid);
    assign wr_match2 = wb_valid & (rename_op2[TAGW-1:0] == wb_robid);
    assign wr_rdy1   = rename_op1ready | wr_match1;
    assign wr_rdy2   = rename_op2ready | wr_match2;
    assign wr_val1   = (!rename_op1ready && wr_match1) ? wb_result : rename_op1;
    assign wr_val2   = (!rename_op2ready && wr_match2) ? wb_result : rename_op2;

    // Lowest-index free slot and lowest-index eligible entry. Scanning
    // downward lets the lowest index overwrite any higher one.
    always_comb begin
        free_idx = '0;
        sel_idx  = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!ent_valid[i]) free_idx = IDXW'(i);
            if (eligible[i])   sel_idx  = IDXW'(i);
        end
    end

    // Entry storage. A not-ready operand keeps its tag in the low bits of
    // its value field until the matching result arrives. The slot being
    // written is free, so it can never be the entry selected for issue.
    always_ff @(posedge clk) begin
        if (clear) begin
            ent_valid <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (write_en && free_idx == IDXW'(i)) begin
                    ent_valid[i] <= 1'b1;
                    ent_op[i]    <= rename_op;
                    ent_robid[i] <= rename_robid;
                    ent_rd[i]    <= rename_rd;
                    ent_rdy1[i]  <= wr_rdy1;
                    ent_val1[i]  <= wr_val1;
                    ent_rdy2[i]  <= wr_rdy2;
                    ent_val2[i]  <= wr_val2;
                    ent_imm[i]   <= rename_imm;
                end else begin
                    if (issue_load && sel_idx == IDXW'(i)) begin
                        ent_valid[i] <= 1'b0;
                    end
                    if (wb_valid && ent_valid[i] && !ent_rdy1[i] &&
                        ent_val1[i][TAGW-1:0] == wb_robid) begin
                        ent_rdy1[i] <= 1'b1;
                        ent_val1[i] <= wb_result;
                    end
                    if (wb_valid && ent_valid[i] && !ent_rdy2[i] &&
                        ent_val2[i][TAGW-1:0] == wb_robid) begin
                        ent_rdy2[i] <= 1'b1;
                        ent_val2[i] <= wb_result;
                    end
                end
            end
        end
    end

    // Issue slot: refills whenever it is empty or being consumed, empties
    // when consumed with nothing to replace it, and holds under alu_stall.
    always_ff @(posedge clk) begin
        if (clear) begin
            exers_issue_valid <= 1'b0;
            exers_issue_op    <= '0;
            exers_issue_robid <= '0;
            exers_issue_rd    <= '0;
            exers_issue_op1   <= '0;
            exers_issue_op2   <= '0;
            exers_issue_imm   <= '0;
        end else if (issue_load) begin
            exers_issue_valid <= 1'b1;
            exers_issue_op    <= ent_op[sel_idx];
            exers_issue_robid <= ent_robid[sel_idx];
            exers_issue_rd    <= ent_rd[sel_idx];
            exers_issue_op1   <= ent_val1[sel_idx];
            exers_issue_op2   <= ent_val2[sel_idx];
            exers_issue_imm   <= ent_imm[sel_idx];
        end else if (!alu_stall) begin
            exers_issue_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_exers.sv
// tb_exers: self-checking bench for the exers reservation station.
// A behavioural model of the station (entry list plus issue slot) is
// stepped at every rising edge from the same inputs the DUT sees; a compare
// process checks stall, issue valid and issue data on every falling edge.
// Directed scenarios add literal expectations, then randomized traffic runs.
module tb_exers;

    localparam int DEPTH = 8;
    localparam int TAGW  = 7;

    logic            clk = 1'b0;
    logic            rst;
    logic            rename_exers_write;
    logic [4:0]      rename_op;
    logic [TAGW-1:0] rename_robid;
    logic [5:0]      rename_rd;
    logic            rename_op1ready;
    logic [31:0]     rename_op1;
    logic            rename_op2ready;
    logic [31:0]     rename_op2;
    logic [31:0]     rename_imm;
    logic            exers_stall;
    logic            wb_valid;
    logic [TAGW-1:0] wb_robid;
    logic [31:0]     wb_result;
    logic            alu_stall;
    logic            exers_issue_valid;
    logic [4:0]      exers_issue_op;
    logic [TAGW-1:0] exers_issue_robid;
    logic [5:0]      exers_issue_rd;
    logic [31:0]     exers_issue_op1;
    logic [31:0]     exers_issue_op2;
    logic [31:0]     exers_issue_imm;
    logic            rob_flush;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    exers #(.DEPTH(DEPTH), .TAGW(TAGW)) dut (
        .clk                (clk),
        .rst                (rst),
        .rename_exers_write (rename_exers_write),
        .rename_op          (rename_op),
        .rename_robid       (rename_robid),
        .rename_rd          (rename_rd),
        .rename_op1ready    (rename_op1ready),
        .rename_op1         (rename_op1),
        .rename_op2ready    (rename_op2ready),
        .rename_op2         (rename_op2),
        .rename_imm         (rename_imm),
        .exers_stall        (exers_stall),
        .wb_valid           (wb_valid),
        .wb_robid           (wb_robid),
        .wb_result          (wb_result),
        .alu_stall          (alu_stall),
        .exers_issue_valid  (exers_issue_valid),
        .exers_issue_op     (exers_issue_op),
        .exers_issue_robid  (exers_issue_robid),
        .exers_issue_rd     (exers_issue_rd),
        .exers_issue_op1    (exers_issue_op1),
        .exers_issue_op2    (exers_issue_op2),
        .exers_issue_imm    (exers_issue_imm),
        .rob_flush          (rob_flush)
    );

    always #5 clk = ~clk;

    // Behavioural model: a list of micro-op records and one issue record.
    typedef struct packed {
        logic            v;
        logic [4:0]      op;
        logic [TAGW-1:0] robid;
        logic [5:0]      rd;
        logic            r1;
        logic [31:0]     v1;
        logic            r2;
        logic [31:0]     v2;
        logic [31:0]     imm;
    } uop_t;

    uop_t m_ent [DEPTH];
    uop_t m_iss;

    task automatic check_output(input string name, input logic [127:0] act,
                                input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // One clock edge of the station as described behaviourally: decide the
    // issue from the state before the edge, apply wakeups, then place the
    // accepted dispatch in the lowest free slot.
    task automatic model_step();
        uop_t nxt [DEPTH];
        uop_t niss;
        uop_t w;
        int   sel;
        int   slot;
        bit   full;
        if (rst || rob_flush) begin
            for (int i = 0; i < DEPTH; i++) m_ent[i].v = 1'b0;
            m_iss = '0;
            return;
        end
        for (int i = 0; i < DEPTH; i++) nxt[i] = m_ent[i];
        niss = m_iss;
        full = 1'b1;
        sel  = -1;
        slot = -1;
        for (int i = 0; i < DEPTH; i++) begin
            if (!m_ent[i].v) begin
                full = 1'b0;
                if (slot < 0) slot = i;
            end
            if (sel < 0 && m_ent[i].v && m_ent[i].r1 && m_ent[i].r2) sel = i;
        end
        if ((!m_iss.v || !alu_stall) && sel >= 0) begin
            niss = m_ent[sel];
            nxt[sel].v = 1'b0;
        end else if (!alu_stall) begin
            niss.v = 1'b0;
        end
        if (wb_valid) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (m_ent[i].v && !m_ent[i].r1 && m_ent[i].v1[TAGW-1:0] == wb_robid) begin
                    nxt[i].r1 = 1'b1;
                    nxt[i].v1 = wb_result;
                end
                if (m_ent[i].v && !m_ent[i].r2 && m_ent[i].v2[TAGW-1:0] == wb_robid) begin
                    nxt[i].r2 = 1'b1;
                    nxt[i].v2 = wb_result;
                end
            end
        end
        if (rename_exers_write && !full) begin
            w.v     = 1'b1;
            w.op    = rename_op;
            w.robid = rename_robid;
            w.rd    = rename_rd;
            w.imm   = rename_imm;
            w.r1    = rename_op1ready;
            w.v1    = rename_op1;
            w.r2    = rename_op2ready;
            w.v2    = rename_op2;
            if (!w.r1 && wb_valid && w.v1[TAGW-1:0] == wb_robid) begin
                w.r1 = 1'b1;
                w.v1 = wb_result;
            end
            if (!w.r2 && wb_valid && w.v2[TAGW-1:0] == wb_robid) begin
                w.r2 = 1'b1;
                w.v2 = wb_result;
            end
            nxt[slot] = w;
        end
        for (int i = 0; i < DEPTH; i++) m_ent[i] = nxt[i];
        m_iss = niss;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic drive_idle();
        rst                = 1'b0;
        rob_flush          = 1'b0;
        rename_exers_write = 1'b0;
        wb_valid           = 1'b0;
        alu_stall          = 1'b0;
    endtask

    task automatic apply_stimulus(input logic [4:0] op, input logic [TAGW-1:0] robid,
                                  input logic [5:0] rd, input logic r1,
                                  input logic [31:0] v1, input logic r2,
                                  input logic [31:0] v2, input logic [31:0] imm);
        rename_exers_write = 1'b1;
        rename_op          = op;
        rename_robid       = robid;
        rename_rd          = rd;
        rename_op1ready    = r1;
        rename_op1         = v1;
        rename_op2ready    = r2;
        rename_op2         = v2;
        rename_imm         = imm;
    endtask

    task automatic drive_wb(input logic [TAGW-1:0] tag, input logic [31:0] res);
        wb_valid  = 1'b1;
        wb_robid  = tag;
        wb_result = res;
    endtask

    // Per-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            bit exp_stall;
            exp_stall = 1'b1;
            for (int i = 0; i < DEPTH; i++) if (!m_ent[i].v) exp_stall = 1'b0;
            check_output("stall", 128'(exers_stall), 128'(exp_stall));
            check_output("issue_valid", 128'(exers_issue_valid), 128'(m_iss.v));
            check_output("issue_data",
                128'({exers_issue_op, exers_issue_robid, exers_issue_rd,
                      exers_issue_op1, exers_issue_op2, exers_issue_imm}),
                128'({m_iss.op, m_iss.robid, m_iss.rd, m_iss.v1, m_iss.v2, m_iss.imm}));
        end
    end

    initial begin
        logic [31:0] rv;
        for (int i = 0; i < DEPTH; i++) m_ent[i] = '0;
        m_iss = '0;
        drive_idle();
        rst = 1'b1;
        rename_op = '0; rename_robid = '0; rename_rd = '0;
        rename_op1ready = 1'b0; rename_op1 = '0;
        rename_op2ready = 1'b0; rename_op2 = '0; rename_imm = '0;
        wb_robid = '0; wb_result = '0;
        tick();
        tick();
        drive_idle();
        check_output("reset_issue_valid", 128'(exers_issue_valid), 128'(0));
        check_output("reset_stall", 128'(exers_stall), 128'(0));
        check_output("reset_issue_op1", 128'(exers_issue_op1), 128'(0));
        check_output("reset_issue_robid", 128'(exers_issue_robid), 128'(0));
        cmp_en = 1'b1;

        // Ready dispatch: issues one edge after the write edge.
        apply_stimulus(5'd3, 7'd5, 6'd1, 1'b1, 32'd10, 1'b1, 32'd20, 32'h0);
        tick();
        drive_idle();
        check_output("ready_not_yet", 128'(exers_issue_valid), 128'(0));
        tick();
        check_output("ready_valid", 128'(exers_issue_valid), 128'(1));
        check_output("ready_op", 128'(exers_issue_op), 128'(3));
        check_output("ready_robid", 128'(exers_issue_robid), 128'(5));
        check_output("ready_op1", 128'(exers_issue_op1), 128'(10));
        check_output("ready_op2", 128'(exers_issue_op2), 128'(20));
        tick();
        check_output("ready_freed", 128'(exers_issue_valid), 128'(0));

        // Wakeup from the result bus.
        apply_stimulus(5'd4, 7'd8, 6'd2, 1'b0, 32'hFFFF_FF09, 1'b1, 32'd3, 32'd1);
        tick();
        drive_idle();
        tick();
        tick();
        drive_wb(7'd9, 32'h1234);
        tick();
        drive_idle();
        check_output("wakeup_not_yet", 128'(exers_issue_valid), 128'(0));
        tick();
        check_output("wakeup_valid", 128'(exers_issue_valid), 128'(1));
        check_output("wakeup_op1", 128'(exers_issue_op1), 128'(32'h1234));
        tick();

        // Same-cycle write/wakeup bypass.
        apply_stimulus(5'd7, 7'd13, 6'd3, 1'b1, 32'd1, 1'b0, 32'd12, 32'd2);
        drive_wb(7'd12, 32'd7);
        tick();
        drive_idle();
        tick();
        check_output("bypass_valid", 128'(exers_issue_valid), 128'(1));
        check_output("bypass_op2", 128'(exers_issue_op2), 128'(7));
        tick();

        // Fill the station, hold a rejected 9th write, then free slot 0.
        for (int i = 0; i < DEPTH; i++) begin
            apply_stimulus(5'd4, TAGW'(40 + i), 6'(i), 1'b0,
                           32'hFFFF_FF80 | 32'(40 + i), 1'b1, 32'd1, 32'(i));
            tick();
        end
        drive_idle();
        check_output("full_stall", 128'(exers_stall), 128'(1));
        apply_stimulus(5'd9, 7'd99, 6'd9, 1'b1, 32'h99, 1'b1, 32'h98, 32'h97);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_output("held_stall", 128'(exers_stall), 128'(1));
        end
        drive_wb(7'd40, 32'h40);
        tick();
        wb_valid = 1'b0;
        tick();
        check_output("full_issue_robid", 128'(exers_issue_robid), 128'(40));
        check_output("full_issue_op1", 128'(exers_issue_op1), 128'(32'h40));
        check_output("full_stall_drop", 128'(exers_stall), 128'(0));
        tick();
        drive_idle();
        check_output("refill_stall", 128'(exers_stall), 128'(1));
        tick();
        check_output("ninth_robid", 128'(exers_issue_robid), 128'(99));
        rob_flush = 1'b1;
        tick();
        drive_idle();

        // ALU backpressure.
        alu_stall = 1'b1;
        apply_stimulus(5'd1, 7'd1, 6'd1, 1'b1, 32'd100, 1'b1, 32'd101, 32'd0);
        tick();
        apply_stimulus(5'd2, 7'd2, 6'd2, 1'b1, 32'd200, 1'b1, 32'd201, 32'd0);
        tick();
        rename_exers_write = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check_output("bp_hold_robid", 128'(exers_issue_robid), 128'(1));
            check_output("bp_hold_op", 128'(exers_issue_op), 128'(1));
            tick();
        end
        alu_stall = 1'b0;
        tick();
        check_output("bp_release_robid", 128'(exers_issue_robid), 128'(2));
        tick();

        // Flush with a valid issue and four waiting entries.
        apply_stimulus(5'd5, 7'd60, 6'd5, 1'b1, 32'd6, 1'b1, 32'd7, 32'd8);
        tick();
        alu_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(5'd6, TAGW'(20 + i), 6'(i), 1'b0, 32'(70 + i), 1'b1, 32'd0, 32'd0);
            tick();
        end
        check_output("pre_flush_valid", 128'(exers_issue_valid), 128'(1));
        check_output("pre_flush_robid", 128'(exers_issue_robid), 128'(60));
        alu_stall = 1'b0;
        rob_flush = 1'b1;
        apply_stimulus(5'd1, 7'd80, 6'd0, 1'b1, 32'd1, 1'b1, 32'd1, 32'd0);
        drive_wb(7'd70, 32'd5);
        tick();
        drive_idle();
        check_output("flush_valid", 128'(exers_issue_valid), 128'(0));
        check_output("flush_stall", 128'(exers_stall), 128'(0));
        for (int i = 0; i < 4; i++) begin
            drive_wb(TAGW'(70 + i), 32'(i));
            tick();
        end
        drive_idle();
        tick();
        check_output("flush_no_issue", 128'(exers_issue_valid), 128'(0));

        // Randomized traffic over a small tag pool so wakeups hit often.
        for (int c = 0; c < 3000; c++) begin
            drive_idle();
            if ($urandom_range(99) < 60) begin
                logic [31:0] a;
                logic [31:0] b;
                logic        r1;
                logic        r2;
                r1 = 1'($urandom_range(1));
                r2 = 1'($urandom_range(1));
                a  = $urandom;
                b  = $urandom;
                if (!r1) a[6:0] = 7'($urandom_range(15));
                if (!r2) b[6:0] = 7'($urandom_range(15));
                rv = $urandom;
                apply_stimulus(rv[4:0], TAGW'($urandom_range(15)), rv[10:5],
                               r1, a, r2, b, $urandom);
            end
            if ($urandom_range(99) < 50) drive_wb(TAGW'($urandom_range(15)), $urandom);
            alu_stall = ($urandom_range(99) < 30);
            rob_flush = ($urandom_range(99) < 1);
            rst       = ($urandom_range(199) < 1);
            tick();
        end
        drive_idle();
        tick();
        tick();
        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
